triangle_cmd_encoder: RTL
=========================

// Module: triangle_cmd_encoder
// PURPOSE
//  Host-side transmitter for the triangle command protocol; inverse of the GPU input decoder.
//  Accepts one triangle (TexNum + 3 vertices) or a frame-end request; serialises to 32-bit FIFO words.
//  Triangle = header {OPC_TRI,20'b0,TexNum}, then {x1,y1}, {x2,y2}, {x3,y3}.
//  Frame end = one word {OPC_FRAME,12'b0,tri_count}. Drives the command FIFO write port.
// PARAMETERS
//  OPC_TRI    4'd1  opcode in bits [31:28] of the triangle header word
//  OPC_FRAME  4'd2  opcode in bits [31:28] of the frame-end word
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  tri_valid    in   1   triangle fields valid
//  tri_ready    out  1   encoder can accept a triangle this cycle
//  tex_num      in   8   texture number
//  x1,y1,x2,y2,x3,y3  in  16 each  vertex coordinates
//  frame_req    in   1   request frame-end word; level, held until frame_ack
//  frame_ack    out  1   1-cycle pulse: frame-end word written
//  fifo_full    in   1   command FIFO full
//  fifo_write   out  1   FIFO write strobe
//  fifo_w_data  out  32  FIFO write data
//  busy         out  1   state != IDLE
//  tri_count    out  16  triangles fully written since last frame end
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all captured regs, tri_count=0; fifo_write=0, fifo_w_data=0, frame_ack=0.
//  States: IDLE, HDR, V1, V2, V3, FRM.
//  tri_ready = (state==IDLE). Accept when tri_valid&&tri_ready: capture tex_num and all coordinates; go to HDR.
//  IDLE with frame_req=1 and tri_valid=0: go to FRM. Both high in IDLE: triangle wins; frame_req is served after V3.
//  Emit states: fifo_write = !fifo_full (combinational); fifo_w_data = the state's word.
//    Word is driven even while full; a word counts as written only on a cycle with fifo_write=1.
//  Advance only on a written word: HDR->V1->V2->V3->IDLE; FRM->IDLE.
//  fifo_full stalls the current state with data held; no word is dropped or duplicated.
//  IDLE: fifo_write=0, fifo_w_data=0.
//  Latency: triangle accepted at edge T; with FIFO never full, header is written in cycle T+1, V3 in T+4.
//  Next accept possible in cycle T+5 (throughput 1 triangle / 5 cycles). Frame word: written in the cycle after entry.
//  Captured registers are frozen from accept until V3 is written; input changes have no effect.
//  tri_count: +1 on the cycle V3 is written; saturates at 16'hFFFF (no wrap).
//  FRM word payload = tri_count value at that cycle. On the write: tri_count<=0 and frame_ack=1 for 1 cycle.
//  frame_req deasserted while in FRM: word is still sent (request is committed once FRM is entered).
//  Reset mid-operation: the partial packet is abandoned; IDLE immediately; no further writes until a new accept.
//  Header bits [27:8] and frame word bits [27:16] are always 0. Coordinates are passed through unmodified.
// TESTING
//  1 Reset, fifo_full=0, tex=8'h05, v=(1,2),(3,4),(5,6) -> words 1000_0005, 0001_0002, 0003_0004, 0005_0006 in consecutive cycles.
//  2 Same triangle, fifo_full=1 for 3 cycles during V2 -> V2 word held stable, written once; total 4 writes, in order.
//  3 Two triangles then frame_req -> third word stream ends 2000_0002; frame_ack pulses once; tri_count -> 0.
//  4 tri_valid and frame_req high together in IDLE -> 4 triangle words, then 2000_0001.
//  5 reset pulsed low during V1 -> fifo_write=0 immediately; tri_count=0; next triangle restarts at header.
//  6 Inputs changed while busy; tri_valid held -> second triangle accepted only in cycle T+5; first packet unchanged.

Source files
------------

// File: rtl/triangle_cmd_encoder_if.sv
// Command-encoder bus: host-side triangle/frame handshake plus the
// command FIFO write port. The encoder takes the slave view; the host and
// FIFO environment take the master view.
interface triangle_cmd_encoder_if;
  logic        tri_valid;
  logic        tri_ready;
  logic [7:0]  tex_num;
  logic [15:0] x1;
  logic [15:0] y1;
  logic [15:0] x2;
  logic [15:0] y2;
  logic [15:0] x3;
  logic [15:0] y3;
  logic        frame_req;
  logic        frame_ack;
  logic        fifo_full;
  logic        fifo_write;
  logic [31:0] fifo_w_data;
  logic        busy;
  logic [15:0] tri_count;

  modport master (
    output tri_valid, tex_num, x1, y1, x2, y2, x3, y3, frame_req, fifo_full,
    input  tri_ready, frame_ack, fifo_write, fifo_w_data, busy, tri_count
  );

  modport slave (
    input  tri_valid, tex_num, x1, y1, x2, y2, x3, y3, frame_req, fifo_full,
    output tri_ready, frame_ack, fifo_write, fifo_w_data, busy, tri_count
  );
endinterface

// File: rtl/triangle_cmd_encoder.sv
// Triangle command encoder: serialises one triangle (header + 3 vertex
// words) or a frame-end word onto the 32-bit command FIFO write port.
// Words are held on fifo_w_data while the FIFO is full and the state only
// advances on a cycle where the word is actually written.
module triangle_cmd_encoder #(
  parameter logic [3:0] OPC_TRI   = 4'd1,
  parameter logic [3:0] OPC_FRAME = 4'd2
) (
  input  logic                  clk,
  input  logic                  reset,
  triangle_cmd_encoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR, V1, V2, V3, FRM} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tex_q, tex_d;
  logic [31:0] v1_q, v1_d;
  logic [31:0] v2_q, v2_d;
  logic [31:0] v3_q, v3_d;
  logic [15:0] count_q, count_d;

  logic        emit;
  logic        write_en;
  logic        ack;
  logic [31:0] word;

  // State and captured packet fields; reset abandons any partial packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tex_q   <= 8'd0;
      v1_q    <= 32'd0;
      v2_q    <= 32'd0;
      v3_q    <= 32'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      tex_q   <= tex_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      count_q <= count_d;
    end
  end

  // Next state, capture, output word selection and triangle counting.
  always_comb begin
    state_d  = state_q;
    tex_d    = tex_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    count_d  = count_q;
    emit     = 1'b0;
    word     = 32'd0;
    write_en = 1'b0;
    ack      = 1'b0;

    case (state_q)
      IDLE: begin
        // A pending triangle takes priority; a held frame_req is picked up
        // once the triangle packet has drained back to IDLE.
        if (bus.tri_valid) begin
          tex_d   = bus.tex_num;
          v1_d    = {bus.x1, bus.y1};
          v2_d    = {bus.x2, bus.y2};
          v3_d    = {bus.x3, bus.y3};
          state_d = HDR;
        end else if (bus.frame_req) begin
          state_d = FRM;
        end
      end
      HDR: begin
        emit = 1'b1;
        word = {OPC_TRI, 20'd0, tex_q};
      end
      V1: begin
        emit = 1'b1;
        word = v1_q;
      end
      V2: begin
        emit = 1'b1;
        word = v2_q;
      end
      V3: begin
        emit = 1'b1;
        word = v3_q;
      end
      FRM: begin
        emit = 1'b1;
        word = {OPC_FRAME, 12'd0, count_q};
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    write_en = emit && !bus.fifo_full;

    // Advance only on a written word.
    if (write_en) begin
      case (state_q)
        HDR: state_d = V1;
        V1:  state_d = V2;
        V2:  state_d = V3;
        V3: begin
          state_d = IDLE;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
        end
        FRM: begin
          state_d = IDLE;
          count_d = 16'd0;
          ack     = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.tri_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.fifo_write  = write_en;
  assign bus.fifo_w_data = word;
  assign bus.frame_ack   = ack;
  assign bus.tri_count   = count_q;

endmodule
